// File: rtl/srec_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : srec_uart_loader
// Purpose  : Parses a Motorola S-record byte stream (S0/S3/S7) coming from
//            the UART receiver. S3 payload is merged into 32-bit words and
//            written to L2 through a request/grant port. The S7 address is
//            reported as the boot entry point.
// Ports    : clk_i/rst_i      clock, async active-high reset
//            enable_i         loader armed; low returns to IDLE
//            rx_*             UART byte stream (valid/ready)
//            mem_*            word write port (req/gnt, addr, wdata, be, we)
//            entry_o/done_o   S7 entry address and completion flag
//            error_o/err_code_o sticky parse error and its cause
// Revision : 1.0  initial release
// ============================================================================
module srec_uart_loader #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  output logic                  mem_we_o,
  output logic [31:0]           entry_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [2:0]            err_code_o
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_WAITS = 3'd1;
  localparam logic [2:0] c_ST_TYPE  = 3'd2;
  localparam logic [2:0] c_ST_FIELD = 3'd3;
  localparam logic [2:0] c_ST_FLUSH = 3'd4;
  localparam logic [2:0] c_ST_DONE  = 3'd5;
  localparam logic [2:0] c_ST_ERROR = 3'd6;

  localparam logic [1:0] c_T_S0 = 2'd0;
  localparam logic [1:0] c_T_S3 = 2'd1;
  localparam logic [1:0] c_T_S7 = 2'd2;

  localparam logic [2:0] c_E_HEX   = 3'd1;
  localparam logic [2:0] c_E_CSUM  = 3'd2;
  localparam logic [2:0] c_E_TYPE  = 3'd3;
  localparam logic [2:0] c_E_COUNT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            rtype_q, rtype_d;
  logic                  have_hi_q, have_hi_d;
  logic [3:0]            hi_q, hi_d;
  logic                  cnt_phase_q, cnt_phase_d;   // next byte is the count
  logic [7:0]            rem_q, rem_d;               // bytes left incl. current
  logic [2:0]            addr_left_q, addr_left_d;
  logic [7:0]            sum_q, sum_d;
  logic [31:0]           addr_q, addr_d;             // byte address for data
  logic [31:0]           wbuf_q, wbuf_d;
  logic [3:0]            be_q, be_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           entry_q, entry_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [2:0]            err_code_q, err_code_d;

  logic                  w_acc;
  logic                  w_is_hex;
  logic [3:0]            w_nib;
  logic [7:0]            w_byte;
  logic [7:0]            w_sum;
  logic [1:0]            w_lane;
  logic [31:0]           w_merged;
  logic [3:0]            w_be_new;
  logic                  w_count_bad;

  assign rx_ready_o = enable_i && ((state_q == c_ST_WAITS) ||
                                   (state_q == c_ST_TYPE)  ||
                                   (state_q == c_ST_FIELD));
  assign w_acc      = rx_valid_i && rx_ready_o;
  assign w_byte     = {hi_q, w_nib};
  assign w_sum      = sum_q + w_byte;
  assign w_lane     = addr_q[1:0];
  assign w_be_new   = be_q | (4'b0001 << w_lane);

  // ASCII hex digit decode; letters map through their low nibble plus 9.
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = 4'h0;
    if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
      w_is_hex = 1'b1;
      w_nib    = rx_data_i[3:0];
    end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                 (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = rx_data_i[3:0] + 4'd9;
    end
  end

  always_comb begin
    w_merged = wbuf_q;
    case (w_lane)
      2'd0:    w_merged[7:0]   = w_byte;
      2'd1:    w_merged[15:8]  = w_byte;
      2'd2:    w_merged[23:16] = w_byte;
      default: w_merged[31:24] = w_byte;
    endcase
  end

  always_comb begin
    case (rtype_q)
      c_T_S3:  w_count_bad = (w_byte < 8'd5);
      c_T_S7:  w_count_bad = (w_byte != 8'd5);
      default: w_count_bad = (w_byte < 8'd3);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rtype_d     = rtype_q;
    have_hi_d   = have_hi_q;
    hi_d        = hi_q;
    cnt_phase_d = cnt_phase_q;
    rem_d       = rem_q;
    addr_left_d = addr_left_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    wbuf_d      = wbuf_q;
    be_d        = be_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    entry_d     = entry_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;

    case (state_q)
      c_ST_IDLE: begin
        if (enable_i) state_d = c_ST_WAITS;
      end
      c_ST_WAITS: begin
        if (w_acc && rx_data_i == 8'h53) state_d = c_ST_TYPE;
      end
      c_ST_TYPE: begin
        if (w_acc) begin
          have_hi_d   = 1'b0;
          cnt_phase_d = 1'b1;
          sum_d       = 8'h00;
          addr_d      = 32'h0;
          wbuf_d      = 32'h0;
          be_d        = 4'h0;
          state_d     = c_ST_FIELD;
          case (rx_data_i)
            8'h30:   rtype_d = c_T_S0;
            8'h33:   rtype_d = c_T_S3;
            8'h37:   rtype_d = c_T_S7;
            default: begin
              state_d    = c_ST_ERROR;
              err_d      = 1'b1;
              err_code_d = c_E_TYPE;
            end
          endcase
        end
      end
      c_ST_FIELD: begin
        if (w_acc) begin
          if (!w_is_hex) begin
            state_d    = c_ST_ERROR;
            err_d      = 1'b1;
            err_code_d = c_E_HEX;
          end else if (!have_hi_q) begin
            hi_d      = w_nib;
            have_hi_d = 1'b1;
          end else begin
            have_hi_d = 1'b0;
            sum_d     = w_sum;
            if (cnt_phase_q) begin
              cnt_phase_d = 1'b0;
              rem_d       = w_byte;
              addr_left_d = (rtype_q == c_T_S0) ? 3'd2 : 3'd4;
              if (w_count_bad) begin
                state_d    = c_ST_ERROR;
                err_d      = 1'b1;
                err_code_d = c_E_COUNT;
              end
            end else if (rem_q == 8'd1) begin
              // checksum byte closes the record
              if (w_sum == 8'hFF) begin
                if (rtype_q == c_T_S7) begin
                  entry_d = addr_q;
                  done_d  = 1'b1;
                  state_d = c_ST_DONE;
                end else begin
                  state_d = c_ST_WAITS;
                end
              end else begin
                state_d    = c_ST_ERROR;
                err_d      = 1'b1;
                err_code_d = c_E_CSUM;
              end
            end else begin
              rem_d = rem_q - 8'd1;
              if (addr_left_q != 3'd0) begin
                addr_d      = {addr_q[23:0], w_byte};
                addr_left_d = addr_left_q - 3'd1;
              end else if (rtype_q == c_T_S3) begin
                wbuf_d = w_merged;
                be_d   = w_be_new;
                addr_d = addr_q + 32'd1;
                // flush on a full word or on the last data byte (rem 2 means
                // only the checksum follows)
                if (w_lane == 2'd3 || rem_q == 8'd2) begin
                  mem_req_d   = 1'b1;
                  mem_addr_d  = ADDR_WIDTH'({addr_q[31:2], 2'b00});
                  mem_wdata_d = w_merged;
                  mem_be_d    = w_be_new;
                  wbuf_d      = 32'h0;
                  be_d        = 4'h0;
                  state_d     = c_ST_FLUSH;
                end
              end
            end
          end
        end
      end
      c_ST_FLUSH: begin
        // the handshake always completes, even if the loader is disarmed
        if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = enable_i ? c_ST_FIELD : c_ST_IDLE;
        end
      end
      default: ; // DONE and ERROR hold until disarmed
    endcase

    if (!enable_i && state_q != c_ST_FLUSH) begin
      state_d    = c_ST_IDLE;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = 3'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= c_ST_IDLE;
      rtype_q     <= c_T_S0;
      have_hi_q   <= 1'b0;
      hi_q        <= 4'h0;
      cnt_phase_q <= 1'b0;
      rem_q       <= 8'h00;
      addr_left_q <= 3'd0;
      sum_q       <= 8'h00;
      addr_q      <= 32'h0;
      wbuf_q      <= 32'h0;
      be_q        <= 4'h0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      entry_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
    end else begin
      state_q     <= state_d;
      rtype_q     <= rtype_d;
      have_hi_q   <= have_hi_d;
      hi_q        <= hi_d;
      cnt_phase_q <= cnt_phase_d;
      rem_q       <= rem_d;
      addr_left_q <= addr_left_d;
      sum_q       <= sum_d;
      addr_q      <= addr_d;
      wbuf_q      <= wbuf_d;
      be_q        <= be_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      entry_q     <= entry_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign entry_o     = entry_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign err_code_o  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_srec_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_srec_uart_loader
// Purpose  : Directed self-checking bench for srec_uart_loader: boot image,
//            unaligned record, error codes, grant stall, reset in FLUSH and
//            re-arm after an error.
// Revision : 1.0  initial release
// ============================================================================
module tb_srec_uart_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic [31:0] entry;
  logic        done;
  logic        error;
  logic [2:0]  err_code;

  int          n_chk = 0;
  int          n_bad = 0;
  logic        gnt_hold = 1'b0;
  int          wr_n = 0;
  logic [31:0] log_addr [0:15];
  logic [31:0] log_data [0:15];
  logic [3:0]  log_be   [0:15];

  always #5 clk = ~clk;

  srec_uart_loader #(.ADDR_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .mem_req_o   (mem_req),
    .mem_gnt_i   (mem_gnt),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_we_o    (mem_we),
    .entry_o     (entry),
    .done_o      (done),
    .error_o     (error),
    .err_code_o  (err_code)
  );

  // Memory side: grant as soon as a request is seen unless stalled, and log
  // every write in the cycle its grant is presented.
  always @(negedge clk) begin
    logic g;
    g = mem_req && !gnt_hold;
    if (g) begin
      if (wr_n < 16) begin
        log_addr[wr_n] = mem_addr;
        log_data[wr_n] = mem_wdata;
        log_be[wr_n]   = mem_be;
      end
      wr_n = wr_n + 1;
    end
    mem_gnt = g;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", rx_ready, 1);
    else @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic rearm();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_entry", entry, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", rx_ready, 0);

    // full boot image
    enable = 1'b1;
    @(negedge clk);
    wr_n = 0;
    send_str("\n3 sys ;\nS00B00006D696E2E73726563D5\n");
    send_str("S3091C00088097110000AA\n");
    send_str("S3091C0008B0F5B7000076\n");
    send_str("S7051C00088056");
    chk("boot_done", done, 1);
    chk("boot_entry", entry, 32'h1C000880);
    chk("boot_error", error, 0);
    chk("boot_rx_ready", rx_ready, 0);
    chk("boot_wr_n", wr_n, 2);
    chk("boot_w0_addr", log_addr[0], 32'h1C000880);
    chk("boot_w0_data", log_data[0], 32'h00001197);
    chk("boot_w0_be", log_be[0], 4'hF);
    chk("boot_w1_addr", log_addr[1], 32'h1C0008B0);
    chk("boot_w1_data", log_data[1], 32'h0000B7F5);
    chk("boot_w1_be", log_be[1], 4'hF);

    // unaligned record
    rearm();
    chk("rearm_done_clr", done, 0);
    wr_n = 0;
    send_str("S3071C000001AABB76");
    chk("unal_wr_n", wr_n, 1);
    chk("unal_addr", log_addr[0], 32'h1C000000);
    chk("unal_be", log_be[0], 4'b0110);
    chk("unal_data", log_data[0][23:8], 16'hBBAA);
    chk("unal_error", error, 0);
    chk("unal_rx_ready", rx_ready, 1);

    // bad checksum: write lands, then code 2
    rearm();
    wr_n = 0;
    send_str("S3071C000001AABB77");
    chk("csum_wr_n", wr_n, 1);
    chk("csum_error", error, 1);
    chk("csum_code", err_code, 2);
    rx_valid = 1'b1;
    rx_data  = 8'h53;
    repeat (3) @(negedge clk);
    chk("csum_no_accept", rx_ready, 0);
    rx_valid = 1'b0;

    // bad characters
    rearm();
    chk("err_clr", error, 0);
    send_str("S5");
    chk("type_error", error, 1);
    chk("type_code", err_code, 3);
    rearm();
    send_str("S3G");
    chk("hex_code", err_code, 1);
    rearm();
    send_str("S706");
    chk("count_code", err_code, 4);

    // grant stall for 10 cycles
    rearm();
    wr_n = 0;
    gnt_hold = 1'b1;
    send_str("S3071C000001AABB");
    for (int i = 0; i < 10; i++) begin
      chk("stall_req", mem_req, 1);
      chk("stall_we", mem_we, 1);
      chk("stall_rx_ready", rx_ready, 0);
      chk("stall_addr", mem_addr, 32'h1C000000);
      chk("stall_data", mem_wdata, 32'h00BBAA00);
      chk("stall_be", mem_be, 4'b0110);
      @(negedge clk);
    end
    gnt_hold = 1'b0;
    send_str("76");
    chk("stall_wr_n", wr_n, 1);
    chk("stall_req_drop", mem_req, 0);
    chk("stall_error", error, 0);

    // asynchronous reset while in FLUSH
    rearm();
    gnt_hold = 1'b1;
    send_str("S3071C000001AABB");
    chk("flush_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_be", mem_be, 0);
    chk("arst_wdata", mem_wdata, 0);
    chk("arst_rx_ready", rx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    gnt_hold = 1'b0;
    @(negedge clk);

    // error, then disarm/re-arm and a clean S7
    send_str("S5");
    chk("re_error", error, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("re_error_clr", error, 0);
    chk("re_code_clr", err_code, 0);
    enable = 1'b1;
    @(negedge clk);
    send_str("S7051C00088056");
    chk("re_done", done, 1);
    chk("re_entry", entry, 32'h1C000880);
    chk("re_error_end", error, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/srec_uart_loader.md
# srec_uart_loader

Hardware Motorola S-record loader that consumes the ASCII byte stream arriving from the SoC UART receiver, parses S0/S3/S7 records, writes payload data into L2 through a request/grant memory port and reports the S7 entry point. It replaces the software shell's "boot from UART" path. The boot-mode logic enables it, and the FC jumps to `entry_o` once `done_o` rises.

## Interface
- `ADDR_WIDTH`, default 32: memory address width. S3/S7 addresses are always 32 bit.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  loader armed. Deasserting it returns the block to IDLE from any state.
- `rx_data_i`  in  8  received UART byte.
- `rx_valid_i`  in  1  byte available.
- `rx_ready_o`  out  1  byte accepted when `rx_valid_i && rx_ready_o`.
- `mem_req_o`  out  1  write request.
- `mem_gnt_i`  in  1  request granted.
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned address, `[1:0]` always 0.
- `mem_wdata_o`  out  32  little-endian word.
- `mem_be_o`  out  4  byte enables.
- `mem_we_o`  out  1  always 1 while `mem_req_o` is high.
- `entry_o`  out  32  S7 entry address.
- `done_o`  out  1  S7 record accepted.
- `error_o`  out  1  sticky parse error.
- `err_code_o`  out  3  error code: 0 none, 1 non-hex character, 2 checksum, 3 unsupported type, 4 bad count.

## Operation
- **States:** IDLE, WAIT_S, TYPE, FIELD, FLUSH, DONE, ERROR.
- **IDLE:** `rx_ready_o` = 0. Moves to WAIT_S when `enable_i` = 1.
- **WAIT_S:** discards every byte except `'S'`, which moves to TYPE.
- **TYPE:** `'0'`, `'3'` or `'7'` moves to FIELD. Any other character goes to ERROR with code 3.
- **FIELD:** assembles hex pairs (high nibble first, `0-9`, `A-F` and `a-f` accepted) into bytes.
  - Any other character inside a record goes to ERROR with code 1.
  - Byte order per record: count, then 4 address bytes (S0: 2 address bytes), then data bytes, then checksum.
  - Counter length: 8 bits, covering the count byte.
  - Required counts: S3 count ≥ 5; S7 count = 5; S0 count ≥ 3. A violation goes to ERROR with code 4 as soon as the count byte completes.
- **Checksum:** the 8-bit running sum of count, address, data and checksum bytes must equal 0xFF. A mismatch goes to ERROR with code 2.
- **S0:** payload is discarded; the checksum is still checked.
- **S3 data:** data bytes merge into a word buffer.
  - Byte i goes to lane `addr[1:0]` and sets `be[addr[1:0]]`, then the byte address increments.
  - The buffer is flushed (FLUSH) after lane 3 is written, and after the last data byte of a record if any enable bit is set.
  - Writes are committed before the record checksum is known. Data from a corrupt record may already be in memory when code 2 is raised.
- **S7:** after a good checksum, `entry_o` ← the address field, `done_o` = 1, and the FSM enters DONE.
- **DONE / ERROR:** `rx_ready_o` = 0 in both. The state and `err_code_o` are held until `enable_i` = 0.
- **Between records:** after a good checksum, the FSM returns to WAIT_S. CR, LF and space are therefore ignored between records.

## Timing
- **Reset values:** all outputs 0, state IDLE, word buffer cleared.
- **Byte acceptance:** `rx_ready_o` = 1 in WAIT_S, TYPE and FIELD, at one byte per cycle. The FSM transition is visible the cycle after the accepting edge.
- **FLUSH:** entered the cycle after the completing data byte. `rx_ready_o` = 0 while in FLUSH.
  - `mem_req_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are registered and held stable until the cycle `mem_gnt_i` = 1. A grant in the first request cycle is legal.
  - `mem_req_o` drops the cycle after the grant; the buffer clears and parsing resumes. Minimum FLUSH time is 1 cycle.
- **Last data byte followed by checksum:** the flush completes before the checksum byte is accepted, so no byte is lost.
- **Error and done assertion:** `error_o` and `err_code_o` assert the cycle after the offending byte is accepted. `done_o` asserts the cycle after the S7 checksum byte is accepted.
- **`enable_i` dropped during FLUSH:** the pending request is still held until granted, then the FSM goes to IDLE. The bus is never abandoned mid-handshake.
- **Asynchronous reset mid-operation:** `mem_req_o` drops immediately.

## Test plan
- **Full boot image:** `"\n3 sys ;\nS00B00006D696E2E73726563D5\n"` followed by the S3 records of the minimal program and `"S7051C00088056\n"`.
  - First write: addr 0x1C000880, data 0x00001197, be 0xF.
  - Record `S3091C0008B0F5B7000076` produces addr 0x1C0008B0, data 0x0000B7F5, be 0xF.
  - End state: `done_o` = 1, `entry_o` = 0x1C000880, `error_o` = 0.
- **Unaligned record:** `S3071C000001AABB76` → one write: addr 0x1C000000, be 0110, wdata[23:8] = 0xBBAA.
- **Bad checksum:** the same record ending in `77` → the write still occurs, then `error_o` = 1 and `err_code_o` = 2; no further bytes are accepted.
- **Bad characters:** `"S5..."` → code 3. `"S3G..."` → code 1. `"S7061C..."` → code 4.
- **Grant stall:** hold `mem_gnt_i` = 0 for 10 cycles → `rx_ready_o` = 0 and the request fields are stable throughout; the next byte is accepted after the grant.
- **Reset and re-arm:** assert `rst_i` during FLUSH → all outputs go to 0 immediately. Toggle `enable_i` low then high after an error → error clears and a clean S7 then gives `done_o` = 1.
